// File: rtl/axi_lite_mem_responder.sv
// axi_lite_mem_responder
//   AXI4-Lite responder backed by a word-addressed internal RAM. It stands in
//   for the vendor block memory and shares its port list. After reset the RAM
//   is cleared one word per cycle, and rsta_busy/rstb_busy stay high meanwhile.
//
// Parameters: ADDR_WIDTH, DATA_WIDTH (fixed 32), DEPTH (power of two, >= 4),
//             READ_LATENCY (1..15, AR handshake to rvalid).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rsta_busy, rstb_busy          high during reset and memory clear
//   s_axi_aw*/w*/b*               write address, write data, write response
//   s_axi_ar*/r*                  read address, read data/response
// Build option:
//   AXI_MEM_SLVERR_EN  out-of-range accesses answer SLVERR (write dropped,
//                      read data 0). Undefined: the index wraps modulo DEPTH.
module axi_lite_mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    rsta_busy,
  output logic                    rstb_busy,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_HAVE_A = 2'd1;
  localparam logic [1:0] W_HAVE_D = 2'd2;
  localparam logic [1:0] W_RESP   = 2'd3;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_WAIT   = 2'd1;
  localparam logic [1:0] R_RESP   = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_MEM_SLVERR_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

  // R_WAIT lasts READ_LATENCY-1 cycles; counter loads the remaining-minus-one.
  localparam logic [3:0] LAT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------- clear sequence ----------------
  logic             init_q;
  logic [IDX_W-1:0] init_idx_q;
  logic             busy;

  assign busy      = rst | init_q;
  assign rsta_busy = busy;
  assign rstb_busy = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q     <= 1'b1;
      init_idx_q <= '0;
    end else if (init_q) begin
      init_idx_q <= init_idx_q + 1'b1;
      if (&init_idx_q) init_q <= 1'b0;
    end
  end

`ifdef AXI_MEM_SLVERR_EN
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + 2)) == '0;
  endfunction
`endif

  // ---------------- write channel ----------------
  logic [1:0]            w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, wr_commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;

  assign s_axi_awready = ~busy & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_D));
  assign s_axi_wready  = ~busy & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_A));
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_HAVE_A;
        else if (w_hs)     w_state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)         w_state_d = W_RESP;
      W_HAVE_D: if (aw_hs)        w_state_d = W_RESP;
      W_RESP:   if (s_axi_bready) w_state_d = W_IDLE;
      default:                    w_state_d = W_IDLE;
    endcase
  end

  // The half that arrives in the committing cycle comes straight from the bus.
  assign wr_commit = (w_state_d == W_RESP) && (w_state_q != W_RESP);
  assign wr_addr   = (w_state_q == W_HAVE_A) ? awaddr_q : s_axi_awaddr;
  assign wr_data   = (w_state_q == W_HAVE_D) ? wdata_q  : s_axi_wdata;
  assign wr_strb   = (w_state_q == W_HAVE_D) ? wstrb_q  : s_axi_wstrb;
  assign wr_idx    = wr_addr[IDX_W+1:2];
`ifdef AXI_MEM_SLVERR_EN
  assign wr_ok     = in_range(wr_addr);
`else
  assign wr_ok     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
`ifdef AXI_MEM_SLVERR_EN
      if (wr_commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
`else
      if (wr_commit) bresp_q <= RESP_OKAY;
`endif
    end
  end

  assign s_axi_bvalid = ~rst & (w_state_q == W_RESP);
  assign s_axi_bresp  = s_axi_bvalid ? bresp_q : '0;

  // Memory array: clear port during INIT, byte-masked write otherwise.
  always_ff @(posedge clk) begin
    if (init_q) begin
      mem_q[init_idx_q] <= '0;
    end else if (wr_commit && wr_ok) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  logic [1:0]            r_state_q, r_state_d;
  logic [3:0]            lat_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs, rd_ok;
  logic [IDX_W-1:0]      rd_idx;

  assign s_axi_arready = ~busy & (r_state_q == R_IDLE);
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign rd_idx = s_axi_araddr[IDX_W+1:2];
`ifdef AXI_MEM_SLVERR_EN
  assign rd_ok  = in_range(s_axi_araddr);
`else
  assign rd_ok  = 1'b1;
`endif

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = (READ_LATENCY > 1) ? R_WAIT : R_RESP;
      R_WAIT:  if (lat_cnt_q == 4'd0) r_state_d = R_RESP;
      R_RESP:  if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Capture uses the pre-edge array contents, so a write committing on the
  // same edge stays invisible to this read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      lat_cnt_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        lat_cnt_q <= LAT_INIT;
        rdata_q   <= rd_ok ? mem_q[rd_idx] : '0;
`ifdef AXI_MEM_SLVERR_EN
        rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
`else
        rresp_q   <= RESP_OKAY;
`endif
      end else if (r_state_q == R_WAIT && lat_cnt_q != 4'd0) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
      end else if (r_state_q == R_RESP && s_axi_rready) begin
        rdata_q <= '0;
        rresp_q <= RESP_OKAY;
      end
    end
  end

  assign s_axi_rvalid = ~rst & (r_state_q == R_RESP);
  assign s_axi_rdata  = rst ? '0 : rdata_q;
  assign s_axi_rresp  = rst ? '0 : rresp_q;

  // Address bits outside the word index are intentionally don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// tb_axi_lite_mem_responder
//   Two responders (DEPTH=16) share the write channel and read address:
//   dut1 has READ_LATENCY=1 and carries most traffic, dut3 has READ_LATENCY=3
//   and is read only for the latency/stall case. Expected B/R responses are
//   queued at issue time and popped by a monitor on each handshake.
module tb_axi_lite_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready, arvalid3, rready3;

  logic        busy_a, busy_b, awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        busy_a3, busy_b3, awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0]  bresp3, rresp3;
  logic [31:0] rdata3;

  axi_lite_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .rsta_busy(busy_a), .rstb_busy(busy_b),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  axi_lite_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .rst(rst), .rsta_busy(busy_a3), .rstb_busy(busy_b3),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready3),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready3),
    .s_axi_bresp(bresp3), .s_axi_bvalid(bvalid3), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid3), .s_axi_arready(arready3),
    .s_axi_rdata(rdata3), .s_axi_rresp(rresp3), .s_axi_rvalid(rvalid3), .s_axi_rready(rready3)
  );

  int tests = 0;
  int fails = 0;

  logic [1:0]  qb[$], qb3[$];
  logic [33:0] qr[$], qr3[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (qb.size() == 0) begin tests++; fails++; $display("FAIL b_unexpected: got bresp 0x%0h, expected none", bresp); end
        else check("bresp", 64'(bresp), 64'(qb.pop_front()));
      end
      if (bvalid3 && bready) begin
        if (qb3.size() == 0) begin tests++; fails++; $display("FAIL b3_unexpected: got bresp 0x%0h, expected none", bresp3); end
        else check("bresp_lat3", 64'(bresp3), 64'(qb3.pop_front()));
      end
      if (rvalid && rready) begin
        if (qr.size() == 0) begin tests++; fails++; $display("FAIL r_unexpected: got rdata 0x%0h, expected none", rdata); end
        else check("rresp_rdata", 64'({rresp, rdata}), 64'(qr.pop_front()));
      end
      if (rvalid3 && rready3) begin
        if (qr3.size() == 0) begin tests++; fails++; $display("FAIL r3_unexpected: got rdata 0x%0h, expected none", rdata3); end
        else check("rresp_rdata_lat3", 64'({rresp3, rdata3}), 64'(qr3.pop_front()));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((qb.size() + qb3.size() + qr.size() + qr3.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0",
               qb.size() + qb3.size() + qr.size() + qr3.size());
      qb.delete(); qb3.delete(); qr.delete(); qr3.delete();
    end
    tick();
  endtask

  task automatic wait_ready(input string name, input int which);
    int n = 0;
    while (n < 50 && !((which == 0 && awready) || (which == 1 && wready) ||
                       (which == 2 && awready && wready) || (which == 3 && arready) ||
                       (which == 4 && arready3))) begin
      tick();
      n++;
    end
    if (n == 50) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no ready in 50 cycles, expected ready", name);
    end
  endtask

  // mode 0: AW first, 1: W first, 2: same cycle. Leaves the response pending.
  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input logic [1:0] exp);
    qb.push_back(exp);
    qb3.push_back(exp);
    awaddr = a; wdata = d; wstrb = s;
    if (mode == 0) begin
      awvalid = 1'b1; wait_ready("aw", 0); tick(); awvalid = 1'b0;
      wvalid  = 1'b1; wait_ready("w", 1);  tick(); wvalid  = 1'b0;
    end else if (mode == 1) begin
      wvalid  = 1'b1; wait_ready("w", 1);  tick(); wvalid  = 1'b0;
      awvalid = 1'b1; wait_ready("aw", 0); tick(); awvalid = 1'b0;
    end else begin
      awvalid = 1'b1; wvalid = 1'b1; wait_ready("aww", 2); tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed);
    qr.push_back({er, ed});
    araddr = a;
    arvalid = 1'b1; wait_ready("ar", 3); tick(); arvalid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; arvalid3 = 1'b0;
    bready = 1'b1; rready = 1'b1; rready3 = 1'b1;

    // 1. reset outputs, clear duration, read of cleared word
    tick(); tick();
    check("rst_busy_a", 64'(busy_a), 64'd1);
    check("rst_busy_b", 64'(busy_b), 64'd1);
    check("rst_busy_lat3", 64'({busy_a3, busy_b3}), 64'd3);
    check("rst_readies", 64'({awready, wready, arready}), 64'd0);
    check("rst_valids", 64'({bvalid, rvalid}), 64'd0);
    check("rst_resp_rdata", 64'({bresp, rresp, rdata}), 64'd0);
    tick();
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      check("init_readies", 64'({awready, wready, arready}), 64'd0);
      tick();
      n++;
    end
    check("busy_cycles", 64'(n), 64'd16);
    check("busy_b_after_init", 64'(busy_b), 64'd0);
    check("arready_after_init", 64'(arready), 64'd1);
    do_read(32'h8, 2'b00, 32'h0);

    // 2. write ordering
    issue_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 2'b00); drain();
    issue_write(32'h4, 32'hDEADBEEF, 4'hF, 1, 2'b00); drain();
    issue_write(32'h4, 32'hDEADBEEF, 4'hF, 2, 2'b00); drain();
    do_read(32'h4, 2'b00, 32'hDEADBEEF);

    // 3. byte strobes with B backpressure
    bready = 1'b0;
    issue_write(32'h4, 32'h11223344, 4'b0101, 2, 2'b00);
    for (int k = 0; k < 5; k++) begin
      check("bp_bvalid", 64'({bvalid, bvalid3}), 64'd3);
      check("bp_bresp", 64'(bresp), 64'd0);
      check("bp_readies", 64'({awready, wready, awready3, wready3}), 64'd0);
      tick();
    end
    bready = 1'b1;
    drain();
    do_read(32'h4, 2'b00, 32'hDE22BE44);

    // 4. READ_LATENCY=3 with R stall (dut3)
    rready3 = 1'b0;
    araddr = 32'h4;
    qr3.push_back({2'b00, 32'hDE22BE44});
    arvalid3 = 1'b1; wait_ready("ar3", 4); tick(); arvalid3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("lat3_rvalid_c%0d", k), 64'(rvalid3), (k >= 3) ? 64'd1 : 64'd0);
      if (k >= 3) check($sformatf("lat3_rdata_c%0d", k), 64'(rdata3), 64'hDE22BE44);
      if (k == 6) rready3 = 1'b1;
      tick();
    end
    check("lat3_after_hs", 64'({rvalid3, rdata3}), 64'd0);
    drain();

    // 5. AR on the commit edge of a write to the same word sees old data
    qr.push_back({2'b00, 32'h0});
    araddr = 32'h0;
    arvalid = 1'b1;
    issue_write(32'h0, 32'hA5A5A5A5, 4'hF, 2, 2'b00);
    arvalid = 1'b0;
    drain();
    do_read(32'h0, 2'b00, 32'hA5A5A5A5);

    // 6. out-of-range index 16
`ifdef AXI_MEM_SLVERR_EN
    issue_write(32'h40, 32'hCAFEF00D, 4'hF, 2, 2'b10); drain();
    do_read(32'h40, 2'b10, 32'h0);
    do_read(32'h0, 2'b00, 32'hA5A5A5A5);
`else
    issue_write(32'h40, 32'hCAFEF00D, 4'hF, 2, 2'b00); drain();
    do_read(32'h40, 2'b00, 32'hCAFEF00D);
    do_read(32'h0, 2'b00, 32'hCAFEF00D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
